// File: rtl/tracker_query_arbiter_pkg.sv
// rtl/tracker_query_arbiter_pkg.sv - shared types for the tracker query arbiter
package tracker_query_arbiter_pkg;

  // Default timestamp width used by the pipeline-stage trackers
  localparam int TRACE_TIME_WIDTH = 32;

  // Signed counter timestamp as seen by every stage tracker
  typedef logic signed [TRACE_TIME_WIDTH-1:0] trace_time_t;

  // Query sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } query_state_t;

endpackage

// File: rtl/tracker_query_arbiter_rr_priority_picker.sv
// rtl/tracker_query_arbiter_rr_priority_picker.sv - combinational round-robin winner search
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set bit after last_grant wins
  always_comb begin
    winner = last_grant;
    sum    = '0;
    idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (req_valid[idx]) begin
        winner = idx;
      end
    end
  end

  // Any pending request at all
  always_comb begin
    any = |req_valid;
  end

endmodule

// File: rtl/tracker_query_arbiter.sv
// rtl/tracker_query_arbiter.sv - round-robin sharing of one signal_tracker query port
module tracker_query_arbiter
  import tracker_query_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIME_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] req_start,
  input  logic [NUM_REQ*TIME_WIDTH-1:0] req_end,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          resp_hit,
  output logic [2*TIME_WIDTH-1:0]       range_o,
  output logic                          recalculate_o,
  input  logic                          range_i,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(1);
  localparam logic [IDX_W-1:0]   GRANT_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_BIT     = NUM_REQ'(1);

  query_state_t state;
  query_state_t state_next;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic [IDX_W-1:0] winner;
  logic             any_req;

  logic signed [TIME_WIDTH-1:0] start_arr [NUM_REQ];
  logic signed [TIME_WIDTH-1:0] end_arr   [NUM_REQ];
  logic signed [TIME_WIDTH-1:0] win_start;
  logic signed [TIME_WIDTH-1:0] win_end;
  logic                         win_illegal;
  logic [NUM_REQ-1:0]           win_onehot;
  logic [NUM_REQ-1:0]           held_onehot;

  logic [NUM_REQ-1:0]      req_ready_next;
  logic [NUM_REQ-1:0]      resp_valid_next;
  logic                    resp_hit_next;
  logic [2*TIME_WIDTH-1:0] range_next;
  logic                    recalc_next;
  logic                    busy_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign start_arr[g] = req_start[g*TIME_WIDTH +: TIME_WIDTH];
    assign end_arr[g]   = req_end[g*TIME_WIDTH +: TIME_WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any_req)
  );

  // Winner's window, its legality and the one-hot masks for current and held grant
  always_comb begin
    win_start   = start_arr[winner];
    win_end     = end_arr[winner];
    win_illegal = win_start[TIME_WIDTH-1] || (win_start > win_end);
    win_onehot  = ONE_BIT << winner;
    held_onehot = ONE_BIT << last_grant;
  end

  // State register, grant pointer and lookup-latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_RESET;
      wait_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && any_req) begin
        last_grant <= winner;
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= CNT_LOAD;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // Next-state: illegal windows skip the tracker entirely
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_next = win_illegal ? ST_RESPOND : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          state_next = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Next output values, computed one cycle ahead so every output is a flop
  always_comb begin
    req_ready_next  = '0;
    resp_valid_next = '0;
    resp_hit_next   = 1'b0;
    recalc_next     = 1'b0;
    range_next      = range_o;
    busy_next       = (state_next != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          req_ready_next = win_onehot;
          if (win_illegal) begin
            resp_valid_next = win_onehot;
          end else begin
            recalc_next = 1'b1;
            range_next  = {win_start, win_end};
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == CNT_LAST) begin
          resp_valid_next = held_onehot;
          resp_hit_next   = range_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers; reset drops every pulse immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_hit      <= 1'b0;
      range_o       <= '0;
      recalculate_o <= 1'b0;
      busy          <= 1'b0;
    end else begin
      req_ready     <= req_ready_next;
      resp_valid    <= resp_valid_next;
      resp_hit      <= resp_hit_next;
      range_o       <= range_next;
      recalculate_o <= recalc_next;
      busy          <= busy_next;
    end
  end

endmodule
